fifo_axis_reader: RTL and testbench

FIFO_AXIS_READER -- requirements
Module: fifo_axis_reader

---
 rtl/fifo_axis_reader.sv | 118 +++++++++++
 tb/tb_fifo_axis_reader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_axis_reader.sv
// Drains a show-ahead FIFO into an AXI4-Stream video frame of LINE_PIXELS x FRAME_LINES beats,
// marking start-of-frame on tuser and end-of-line on tlast.
module fifo_axis_reader #(
  parameter int DATA_WIDTH  = 32,
  parameter int LINE_PIXELS = 640,
  parameter int FRAME_LINES = 480
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_enable,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic                  o_tlast,
  output logic                  o_tuser,
  output logic                  o_frame_done,
  output logic                  o_busy
);

  localparam int X_W = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam int Y_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(LINE_PIXELS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(FRAME_LINES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [X_W-1:0]        r_x;
  logic [Y_W-1:0]        r_y;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic                  r_tuser;
  logic                  r_frame_done;

  logic w_pop;
  logic w_accept;
  logic w_x_last;
  logic w_y_last;

  // The output register is refilled on the same edge it is drained, giving full throughput.
  assign w_accept = r_tvalid && i_tready;
  assign w_pop    = (r_state == S_RUN) && !i_fifo_empty && (!r_tvalid || i_tready);
  assign w_x_last = (r_x == X_LAST);
  assign w_y_last = (r_y == Y_LAST);

  // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_enable) w_next = S_RUN;
      S_RUN:   if (w_pop && w_x_last && w_y_last) w_next = S_FLUSH;
      S_FLUSH: if (w_accept) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_x <= '0;
      r_y <= '0;
    end else if (r_state == S_IDLE && i_enable) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_pop) begin
      if (w_x_last) begin
        r_x <= '0;
        r_y <= w_y_last ? '0 : r_y + Y_W'(1);
      end else begin
        r_x <= r_x + X_W'(1);
      end
    end
  end

  // tdata/tlast/tuser only change on a pop, so a stalled beat holds by construction.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_tdata      <= '0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_tuser      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_state == S_FLUSH) && w_accept;
      if (w_pop) begin
        r_tdata  <= i_fifo_data;
        r_tvalid <= 1'b1;
        r_tuser  <= (r_x == '0) && (r_y == '0);
        r_tlast  <= w_x_last;
      end else if (w_accept) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign o_fifo_rd    = w_pop;
  assign o_tdata      = r_tdata;
  assign o_tvalid     = r_tvalid;
  assign o_tlast      = r_tlast;
  assign o_tuser      = r_tuser;
  assign o_frame_done = r_frame_done;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Bench for fifo_axis_reader: a queue-based FIFO and a frame-stream scoreboard,
// driven by a scenario table, randomized traffic and hand-written reset/idle sequences.
module tb_fifo_axis_reader;

  localparam int DW = 16;
  localparam int LP = 4;
  localparam int FL = 2;
  localparam int FB = LP * FL;

  logic          i_clk = 1'b0;
  logic          i_rstn = 1'b0;
  logic          i_enable = 1'b0;
  logic [DW-1:0] i_fifo_data = '0;
  logic          i_fifo_empty = 1'b1;
  logic          i_tready = 1'b0;
  logic          o_fifo_rd;
  logic [DW-1:0] o_tdata;
  logic          o_tvalid;
  logic          o_tlast;
  logic          o_tuser;
  logic          o_frame_done;
  logic          o_busy;

  fifo_axis_reader #(
    .DATA_WIDTH (DW),
    .LINE_PIXELS(LP),
    .FRAME_LINES(FL)
  ) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_enable    (i_enable),
    .i_fifo_data (i_fifo_data),
    .i_fifo_empty(i_fifo_empty),
    .o_fifo_rd   (o_fifo_rd),
    .o_tdata     (o_tdata),
    .o_tvalid    (o_tvalid),
    .i_tready    (i_tready),
    .o_tlast     (o_tlast),
    .o_tuser     (o_tuser),
    .o_frame_done(o_frame_done),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string    name;
    logic [3:0] rdy_pat;    // tready for cycle c is rdy_pat[c%4]
    int       gap_after;    // words loaded up front
    int       gap_cycles;   // cycle at which the remaining words arrive
    int       frames;
    bit       hold_en;
    bit       rnd;          // random tready and random FIFO arrivals
    int       exp_beats;
    int       exp_done;
    int       exp_span;     // cycles from first to last beat, -1 = not checked
  } scn_t;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int beat_idx = 0;
  int beats_got = 0;
  int done_seen = 0;
  int finals = 0;
  int cyc = 0;
  int first_cyc = -1;
  int last_cyc = -1;
  bit prev_final = 1'b0;
  bit prev_stall = 1'b0;
  logic [DW-1:0] hold_data;
  logic hold_last, hold_user;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // Called just after a negedge with i_enable/i_tready set; samples 1 time unit before posedge.
  task automatic tick();
    bit popped;
    logic [DW-1:0] w;
    i_fifo_empty = (fifo_q.size() == 0);
    i_fifo_data  = i_fifo_empty ? '0 : fifo_q[0];
    #4;
    popped = o_fifo_rd;
    check("frame_done_timing", o_frame_done, prev_final);
    if (prev_stall) begin
      check("stall_valid", o_tvalid, 1'b1);
      check("stall_data", o_tdata, hold_data);
      check("stall_last", o_tlast, hold_last);
      check("stall_user", o_tuser, hold_user);
    end
    if (o_fifo_rd)
      check("rd_legal", (!o_tvalid || i_tready) && !i_fifo_empty && o_busy && i_rstn, 1'b1);
    if (!o_busy) check("rd_idle", o_fifo_rd, 1'b0);
    prev_final = 1'b0;
    if (o_tvalid && i_tready) begin
      check("beat_available", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("beat_data", o_tdata, w);
        check("beat_tuser", o_tuser, beat_idx == 0);
        check("beat_tlast", o_tlast, (beat_idx % LP) == LP - 1);
      end
      prev_final = (beat_idx == FB - 1);
      if (prev_final) finals++;
      beat_idx = (beat_idx + 1) % FB;
      beats_got++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
    end
    prev_stall = o_tvalid && !i_tready;
    hold_data  = o_tdata;
    hold_last  = o_tlast;
    hold_user  = o_tuser;
    if (o_frame_done) done_seen++;
    @(posedge i_clk);
    if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
    cyc++;
    @(negedge i_clk);
  endtask

  task automatic run_scn(input scn_t s, input int base);
    logic [DW-1:0] pend[$];
    beats_got = 0;
    done_seen = 0;
    finals    = 0;
    cyc       = 0;
    first_cyc = -1;
    last_cyc  = -1;
    for (int i = 0; i < s.frames * FB; i++) pend.push_back(DW'(base + i));
    if (!s.rnd)
      for (int i = 0; i < s.gap_after && pend.size() > 0; i++) push(pend.pop_front());
    i_enable = 1'b1;
    for (int c = 0; c < 400 && done_seen < s.frames; c++) begin
      i_tready = s.rnd ? ($urandom_range(0, 3) != 0) : s.rdy_pat[c % 4];
      if (s.rnd) begin
        if (pend.size() > 0 && $urandom_range(0, 1) == 1) push(pend.pop_front());
      end else if (c == s.gap_cycles) begin
        while (pend.size() > 0) push(pend.pop_front());
      end
      tick();
      if (!s.hold_en || finals >= s.frames) i_enable = 1'b0;
    end
    check({s.name, "_no_timeout"}, done_seen >= s.frames, 1'b1);
    i_tready = 1'b1;
    repeat (3) tick();
    check({s.name, "_beats"}, beats_got, s.exp_beats);
    check({s.name, "_frame_done"}, done_seen, s.exp_done);
    check({s.name, "_idle"}, o_busy, 1'b0);
    check({s.name, "_drained"}, exp_q.size(), 0);
    if (s.exp_span >= 0) check({s.name, "_span"}, last_cyc - first_cyc, s.exp_span);
  endtask

  scn_t scn_tbl[6];
  scn_t rst_scn;

  initial begin
    scn_tbl[0] = '{"basic",        4'b1111, FB, 0, 1, 1'b0, 1'b0, FB,     1, 7};
    scn_tbl[1] = '{"stall",        4'b0101, FB, 0, 1, 1'b0, 1'b0, FB,     1, -1};
    scn_tbl[2] = '{"fifo_gap",     4'b1111, 3,  5, 1, 1'b0, 1'b0, FB,     1, -1};
    scn_tbl[3] = '{"two_frames",   4'b1111, FB, 0, 2, 1'b1, 1'b0, 2 * FB, 2, 17};
    scn_tbl[4] = '{"random_hold",  4'b1111, 0,  0, 3, 1'b1, 1'b1, 3 * FB, 3, -1};
    scn_tbl[5] = '{"random_pulse", 4'b1111, 0,  0, 1, 1'b0, 1'b1, FB,     1, -1};
    rst_scn    = '{"after_reset",  4'b1111, FB, 0, 1, 1'b0, 1'b0, FB,     1, 7};

    // Reset state
    @(negedge i_clk);
    #1;
    check("rst_tvalid", o_tvalid, 1'b0);
    check("rst_tdata", o_tdata, '0);
    check("rst_tlast", o_tlast, 1'b0);
    check("rst_tuser", o_tuser, 1'b0);
    check("rst_frame_done", o_frame_done, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_fifo_rd", o_fifo_rd, 1'b0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_scn(scn_tbl[i], i * 64);

    // Enable low: a loaded FIFO must be left untouched.
    for (int i = 0; i < 4; i++) push(DW'(16'h0200 + i));
    i_enable = 1'b0;
    i_tready = 1'b1;
    beats_got = 0;
    repeat (10) tick();
    check("noen_beats", beats_got, 0);
    check("noen_fifo_level", fifo_q.size(), 4);
    check("noen_busy", o_busy, 1'b0);
    fifo_q.delete();
    exp_q.delete();

    // Reset mid-frame after beat 5 is accepted, then a fresh frame.
    for (int i = 0; i < FB; i++) push(DW'(16'h0100 + i));
    beats_got = 0;
    i_enable  = 1'b1;
    for (int c = 0; c < 60 && beats_got < 6; c++) begin
      i_tready = 1'b1;
      tick();
      i_enable = 1'b0;
    end
    check("mid_beats_before_reset", beats_got, 6);
    i_rstn = 1'b0;
    #1;
    check("async_rst_tvalid", o_tvalid, 1'b0);
    check("async_rst_busy", o_busy, 1'b0);
    check("async_rst_fifo_rd", o_fifo_rd, 1'b0);
    fifo_q.delete();
    exp_q.delete();
    beat_idx   = 0;
    prev_final = 1'b0;
    prev_stall = 1'b0;
    @(negedge i_clk);
    repeat (2) tick();
    i_rstn = 1'b1;
    run_scn(rst_scn, 16'h00A0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
